wb_aes_stream_ctrl: RTL and testbench
=====================================

WB_AES_STREAM_CTRL -- requirements
Module: wb_aes_stream_ctrl

Interface
REQ-001 SHALL have parameter KEY_W, default 128, meaning key width in bits; legal values 128, 192, 256.
REQ-002 SHALL have parameter RES_DEPTH, default 4, meaning result FIFO depth in 128-bit blocks; power of 2, 2..16.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have Wishbone slave ports wb_cyc_i, wb_stb_i, wb_we_i (in, 1); wb_adr_i (in, 32); wb_sel_i (in, 4, ignored); wb_dat_i (in, 32); wb_dat_o (out, 32); wb_ack_o (out, 1).
REQ-006 SHALL have engine ports: load_o (out, 1, start pulse); decrypt_o (out, 1, mode); data_o (out, 128); key_o (out, KEY_W); ready_i (in, 1, result-valid pulse); data_i (in, 128, result).
REQ-007 SHALL have port irq_o, output, 1, meaning level interrupt.

Function
REQ-008 SHALL decode wb_adr_i[7:0] as: 0x00 CTRL; 0x04 STATUS; 0x10-0x1C DIN words (0x10 = bits 127:96); 0x20 + 4k KEY words, k = 0..KEY_W/32-1, MSW first; 0x40-0x4C RES words (0x40 = bits 127:96).
REQ-009 SHALL define CTRL as: bit0 START (write-1, reads 0); bit1 DECRYPT (R/W, drives decrypt_o); bit2 IRQ_EN (R/W); bit3 FLUSH (write-1, reads 0).
REQ-010 SHALL define STATUS as: bit0 BUSY; bit1 RES_VALID (FIFO not empty); bit2 RES_FULL; bit3 OVF (sticky, write-1-clear); bit4 START_ERR (sticky, write-1-clear); bits[12:8] fill count; other bits 0.
REQ-011 SHALL assert wb_ack_o for exactly one cycle, one cycle after cyc&stb is sampled with ack low; ack SHALL be low for at least one cycle between transfers.
REQ-012 SHALL ack unmapped addresses, ignore writes to them, and return 0 on reads of them.
REQ-013 SHALL register wb_dat_o in the ack cycle; DIN and KEY words SHALL be readable back.
REQ-014 SHALL implement states IDLE, LOAD, WAIT: IDLE->LOAD on START write; LOAD lasts one cycle with load_o=1; LOAD->WAIT; WAIT->IDLE on ready_i.
REQ-015 SHALL hold BUSY=1 in LOAD and WAIT; a START write while BUSY SHALL be ignored and set START_ERR.
REQ-016 SHALL keep data_o, key_o, and decrypt_o stable from LOAD until the return to IDLE; writes to them while BUSY SHALL be ignored.
REQ-017 SHALL push data_i into the FIFO on ready_i in WAIT; if the FIFO is full, the block SHALL be dropped and OVF set.
REQ-018 SHALL ignore ready_i in IDLE or LOAD.
REQ-019 SHALL show the FIFO head on RES reads; a read of 0x4C SHALL pop it, and a pop on an empty FIFO SHALL return 0 with no state change.
REQ-020 SHALL leave the count unchanged and keep ordering on a simultaneous push and pop, including when full.
REQ-021 SHALL empty the FIFO on FLUSH in the same cycle; a push in that cycle SHALL be discarded.
REQ-022 SHALL wrap FIFO pointers modulo RES_DEPTH.

Reset
REQ-023 SHALL, on reset low, immediately force: state IDLE; wb_ack_o, wb_dat_o, load_o, decrypt_o, irq_o = 0; data_o, key_o, and CTRL/STATUS = 0; FIFO empty.
REQ-024 SHALL abandon any WAIT operation on reset; a later ready_i SHALL be ignored.

Configuration
REQ-025 SHALL, with macro WB_AES_IRQ_EN defined, drive irq_o = IRQ_EN & (RES_VALID | OVF).
REQ-026 SHALL, without WB_AES_IRQ_EN, tie irq_o to 0 and make CTRL bit2 read 0 and ignore writes.

Structure
REQ-027 SHALL take register offsets, CTRL/STATUS bit positions, and the IDLE/LOAD/WAIT state type from shared package wb_aes_pkg.
REQ-028 SHALL implement the result FIFO as sub-module aes_res_fifo, parametrised by width 128 and depth RES_DEPTH, with push, pop, flush, full, empty, and count.

Verification
REQ-029 SHALL test encrypt flow: write KEY 000102..0F, DIN 00112233..FF, START; engine returns data_i 69C4E0D8..C55A after 10 cycles -> load_o high 1 cycle, BUSY 1->0, RES reads 69C4E0D8, 6A7B0430, D8CDB780, 70B4C55A, then RES_VALID=0.
REQ-030 SHALL test START while BUSY: START in WAIT -> load_o not re-pulsed, START_ERR=1; write STATUS 0x10 -> START_ERR=0.
REQ-031 SHALL test overflow with RES_DEPTH=4: 5 operations without reads -> count=4, RES_FULL=1, OVF=1, and the first four results read back in order.
REQ-032 SHALL test simultaneous push/pop with a full FIFO: a 0x4C read coincides with ready_i -> count stays 4, no OVF, and the new block is last.
REQ-033 SHALL test reset mid-WAIT: reset low in WAIT, then ready_i -> FIFO empty, BUSY=0, all outputs 0.
REQ-034 SHALL test, with KEY_W=256 and WB_AES_IRQ_EN, that KEY at 0x20-0x3C maps to key_o[255:0] MSW first, and that irq_o rises the cycle after the push and falls after the final pop.

Source files
------------

// File: rtl/wb_aes_pkg.sv
// wb_aes_pkg: register map, CTRL/STATUS bit positions and engine FSM states for wb_aes_stream_ctrl
package wb_aes_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;
  localparam logic [7:0] ADR_CTRL = 8'h00, ADR_STATUS = 8'h04, ADR_DIN = 8'h10,
                         ADR_KEY = 8'h20, ADR_RES = 8'h40, ADR_RES_POP = 8'h4C;
  localparam int CTRL_START = 0, CTRL_DECRYPT = 1, CTRL_IRQ_EN = 2, CTRL_FLUSH = 3;
  localparam int ST_BUSY = 0, ST_RES_VALID = 1, ST_RES_FULL = 2, ST_OVF = 3,
                 ST_START_ERR = 4, ST_CNT_LSB = 8;
endpackage

// File: rtl/aes_res_fifo.sv
// aes_res_fifo: result FIFO with same-cycle flush, read-through head (0 when empty) and drop flag
module aes_res_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign empty  = r_cnt == '0;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign w_pop  = pop & ~empty & ~flush;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_push = push & ~flush & (~full | w_pop);
  assign drop   = push & ~flush & ~w_push;
  assign dout   = empty ? '0 : r_mem[r_rp];
  assign count  = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push != w_pop) r_cnt <= w_push ? r_cnt + 1'b1 : r_cnt - 1'b1;
    end
endmodule

// File: rtl/wb_aes_stream_ctrl.sv
// wb_aes_stream_ctrl: Wishbone front end for an AES engine with a result FIFO.
// Define WB_AES_IRQ_EN to enable CTRL.IRQ_EN and the level interrupt on irq_o.
module wb_aes_stream_ctrl
  import wb_aes_pkg::*;
#(
  parameter int KEY_W     = 128,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             load_o,
  output logic             decrypt_o,
  output logic [127:0]     data_o,
  output logic [KEY_W-1:0] key_o,
  input  logic             ready_i,
  input  logic [127:0]     data_i,
  output logic             irq_o
);
  localparam int NK = KEY_W / 32;
  localparam int CW = $clog2(RES_DEPTH) + 1;
  state_t r_state;
  logic r_ack, r_load, r_dec, r_ovf, r_serr;
  logic [31:0] r_dat, w_rdata;
  logic [127:0] r_din, w_head;
  logic [KEY_W-1:0] r_key;
  logic [CW-1:0] w_cnt;
  logic [7:0] w_a;
  logic w_acc, w_wr, w_rd, w_busy, w_ctrl_wr, w_st_wr, w_start, w_flush, w_pop, w_push;
  logic w_full, w_empty, w_drop, w_ien, w_unused;
  assign w_unused  = ^{wb_sel_i, wb_adr_i[31:8]};
  assign w_a       = wb_adr_i[7:0];
  assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_rd      = w_acc & ~wb_we_i;
  assign w_busy    = r_state != S_IDLE;
  assign w_ctrl_wr = w_wr & (w_a == ADR_CTRL);
  assign w_st_wr   = w_wr & (w_a == ADR_STATUS);
  assign w_start   = w_ctrl_wr & wb_dat_i[CTRL_START];
  assign w_flush   = w_ctrl_wr & wb_dat_i[CTRL_FLUSH];
  assign w_pop     = w_rd & (w_a == ADR_RES_POP);
  assign w_push    = (r_state == S_WAIT) & ready_i;
  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat;
  assign load_o    = r_load;
  assign decrypt_o = r_dec;
  assign data_o    = r_din;
  assign key_o     = r_key;
  aes_res_fifo #(.W(128), .DEPTH(RES_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(w_push), .pop(w_pop), .flush(w_flush), .din(data_i),
    .dout(w_head), .full(w_full), .empty(w_empty), .count(w_cnt), .drop(w_drop)
  );
  always_comb begin
    w_rdata = '0;
    if (w_a == ADR_CTRL) begin
      w_rdata[CTRL_DECRYPT] = r_dec;
      w_rdata[CTRL_IRQ_EN]  = w_ien;
    end
    if (w_a == ADR_STATUS) begin
      w_rdata[ST_BUSY]           = w_busy;
      w_rdata[ST_RES_VALID]      = ~w_empty;
      w_rdata[ST_RES_FULL]       = w_full;
      w_rdata[ST_OVF]            = r_ovf;
      w_rdata[ST_START_ERR]      = r_serr;
      w_rdata[ST_CNT_LSB +: 5]   = 5'(w_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      if (w_a == ADR_DIN + 8'(4*k)) w_rdata = r_din[127-32*k -: 32];
      if (w_a == ADR_RES + 8'(4*k)) w_rdata = w_head[127-32*k -: 32];
    end
    for (int k = 0; k < NK; k++)
      if (w_a == ADR_KEY + 8'(4*k)) w_rdata = r_key[KEY_W-1-32*k -: 32];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_load  <= 1'b0;
      r_dec   <= 1'b0;
      r_ovf   <= 1'b0;
      r_serr  <= 1'b0;
      r_din   <= '0;
      r_key   <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : '0;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state <= S_LOAD;
          r_load  <= 1'b1;
        end
        S_LOAD: begin
          r_state <= S_WAIT;
          r_load  <= 1'b0;
        end
        S_WAIT: if (ready_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_start & w_busy) r_serr <= 1'b1;
      else if (w_st_wr & wb_dat_i[ST_START_ERR]) r_serr <= 1'b0;
      if (w_drop) r_ovf <= 1'b1;
      else if (w_st_wr & wb_dat_i[ST_OVF]) r_ovf <= 1'b0;
      // engine inputs are frozen from LOAD until the result returns
      if (!w_busy) begin
        if (w_ctrl_wr) r_dec <= wb_dat_i[CTRL_DECRYPT];
        for (int k = 0; k < 4; k++)
          if (w_wr && w_a == ADR_DIN + 8'(4*k)) r_din[127-32*k -: 32] <= wb_dat_i;
        for (int k = 0; k < NK; k++)
          if (w_wr && w_a == ADR_KEY + 8'(4*k)) r_key[KEY_W-1-32*k -: 32] <= wb_dat_i;
      end
    end
`ifdef WB_AES_IRQ_EN
  logic r_ien;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_ien <= 1'b0;
    else if (w_ctrl_wr) r_ien <= wb_dat_i[CTRL_IRQ_EN];
  assign w_ien = r_ien;
  assign irq_o = r_ien & (~w_empty | r_ovf);
`else
  assign w_ien = 1'b0;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_aes_stream_ctrl.sv
// tb_wb_aes_stream_ctrl: scoreboard bench for a 128-bit-key instance and a 256-bit-key instance
module tb_wb_aes_stream_ctrl;
`ifdef WB_AES_IRQ_EN
  localparam bit IRQB = 1'b1;
`else
  localparam bit IRQB = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic cyc[2], stb[2], we[2], ack[2], load[2], dec[2], rdy[2], irq[2];
  logic [31:0] adr[2], wdat[2], rdat[2];
  logic [3:0] sel[2];
  logic [127:0] edat[2], dout[2], dout1;
  logic [127:0] key0;
  logic [255:0] key1;
  int total = 0, bad = 0;
  int lcnt[2] = '{0, 0};
  logic [127:0] sb[$];
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int i = 0; i < 2; i++) if (load[i]) lcnt[i] <= lcnt[i] + 1;
  assign dout[1] = dout1;
  wb_aes_stream_ctrl u_dut (
    .clk(clk), .reset(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_ack_o(ack[0]), .load_o(load[0]), .decrypt_o(dec[0]), .data_o(dout[0]),
    .key_o(key0), .ready_i(rdy[0]), .data_i(edat[0]), .irq_o(irq[0])
  );
  wb_aes_stream_ctrl #(.KEY_W(256), .RES_DEPTH(4)) u_dut256 (
    .clk(clk), .reset(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_ack_o(ack[1]), .load_o(load[1]), .decrypt_o(dec[1]), .data_o(dout1),
    .key_o(key1), .ready_i(rdy[1]), .data_i(edat[1]), .irq_o(irq[1])
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wb(input int u, input bit w, input logic [7:0] a, input logic [31:0] d,
                    output logic [31:0] q, input bit wr = 1'b0, input logic [127:0] rv = '0);
    int n;
    @(negedge clk);
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; adr[u] = {24'($urandom), a}; wdat[u] = d; sel[u] = 4'hf;
    if (wr) begin
      rdy[u] = 1'b1;
      edat[u] = rv;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      rdy[u] = 1'b0;
      n++;
    end while (!ack[u] && n < 8);
    check("ack", ack[u], 1);
    q = rdat[u];
    @(negedge clk);
    cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
    @(posedge clk); #1;
    check("ack_lo", ack[u], 0);
  endtask
  task automatic wr(input int u, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb(u, 1'b1, a, d, q);
  endtask
  task automatic rdc(input int u, input logic [7:0] a, input logic [31:0] e, input string tag);
    logic [31:0] q;
    wb(u, 1'b0, a, 32'h0, q);
    check(tag, q, e);
  endtask
  task automatic eng(input int u, input logic [127:0] d, input bit acc);
    @(negedge clk);
    rdy[u] = 1'b1; edat[u] = d;
    @(posedge clk); #1;
    rdy[u] = 1'b0;
    if (u == 0 && acc && sb.size() < 4) sb.push_back(d);
  endtask
  task automatic read_res(input string tag);
    logic [127:0] e;
    e = sb.size() != 0 ? sb.pop_front() : '0;
    for (int k = 0; k < 4; k++) rdc(0, 8'h40 + 8'(4*k), e[127-32*k -: 32], tag);
  endtask
  task automatic op(input int u, input logic [127:0] d, input logic [31:0] ctrl);
    wr(u, 8'h00, ctrl);
    repeat (3) @(posedge clk);
    eng(u, d, 1'b1);
  endtask
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic [127:0] blk, e;
    logic [255:0] e256;
    logic [31:0] q, kw;
    int l;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; rdy[i] = 0; adr[i] = 0; wdat[i] = 0; sel[i] = 0; edat[i] = 0;
    end
    repeat (3) @(posedge clk); #1;
    check("rst_ack", ack[0], 0);
    check("rst_dat", rdat[0], 0);
    check("rst_load", load[0], 0);
    check("rst_irq", irq[0], 0);
    @(negedge clk) rst_n = 1'b1;
    rdc(0, 8'h04, 32'h0, "rst_status");
    rdc(0, 8'h00, 32'h0, "rst_ctrl");
    wr(0, 8'h20, 32'h00010203); wr(0, 8'h24, 32'h04050607);
    wr(0, 8'h28, 32'h08090a0b); wr(0, 8'h2c, 32'h0c0d0e0f);
    wr(0, 8'h10, 32'h00112233); wr(0, 8'h14, 32'h44556677);
    wr(0, 8'h18, 32'h8899aabb); wr(0, 8'h1c, 32'hccddeeff);
    check("data_o", dout[0], 128'h00112233445566778899aabbccddeeff);
    check("key_o", key0, 128'h000102030405060708090a0b0c0d0e0f);
    rdc(0, 8'h14, 32'h44556677, "din_rb");
    rdc(0, 8'h2c, 32'h0c0d0e0f, "key_rb");
    rdc(0, 8'h30, 32'h0, "key_oob");
    l = lcnt[0];
    wr(0, 8'h00, 32'h1);
    rdc(0, 8'h04, 32'h1, "busy");
    check("load_pulse", lcnt[0] - l, 1);
    check("enc_mode", dec[0], 0);
    repeat (6) @(posedge clk);
    eng(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    rdc(0, 8'h04, 32'h102, "st_done");
    read_res("enc_res");
    rdc(0, 8'h04, 32'h0, "st_drained");
    l = lcnt[0];
    wr(0, 8'h00, 32'h1);
    repeat (2) @(posedge clk);
    wr(0, 8'h00, 32'h1);
    wr(0, 8'h10, 32'hdeadbeef);
    check("load_once", lcnt[0] - l, 1);
    check("din_hold", dout[0], 128'h00112233445566778899aabbccddeeff);
    rdc(0, 8'h04, 32'h11, "start_err");
    eng(0, rnd(), 1'b1);
    rdc(0, 8'h04, 32'h112, "start_err_done");
    wr(0, 8'h04, 32'h10);
    rdc(0, 8'h04, 32'h102, "start_err_clr");
    read_res("busy_res");
    eng(0, rnd(), 1'b0);
    rdc(0, 8'h04, 32'h0, "rdy_idle");
    for (int i = 0; i < 5; i++) op(0, rnd(), 32'h1);
    rdc(0, 8'h04, 32'h40e, "ovf");
    for (int i = 0; i < 4; i++) read_res("ovf_order");
    rdc(0, 8'h04, 32'h8, "ovf_sticky");
    wr(0, 8'h04, 32'h8);
    rdc(0, 8'h04, 32'h0, "ovf_clr");
    for (int i = 0; i < 4; i++) op(0, rnd(), 32'h1);
    rdc(0, 8'h04, 32'h406, "full");
    wr(0, 8'h00, 32'h1);
    repeat (3) @(posedge clk);
    blk = rnd();
    e = sb.pop_front();
    wb(0, 1'b0, 8'h4c, 32'h0, q, 1'b1, blk);
    check("pp_word", q, e[31:0]);
    sb.push_back(blk);
    rdc(0, 8'h04, 32'h406, "pp_count");
    for (int i = 0; i < 4; i++) read_res("pp_order");
    op(0, rnd(), 32'h1);
    op(0, rnd(), 32'h1);
    wr(0, 8'h00, 32'h8);
    sb.delete();
    rdc(0, 8'h04, 32'h0, "flush");
    rdc(0, 8'h40, 32'h0, "flush_head");
    wr(0, 8'h00, 32'h2);
    check("dec_on", dec[0], 1);
    rdc(0, 8'h00, 32'h2, "ctrl_dec");
    wr(0, 8'h00, 32'h3);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("rw_load", load[0], 0);
    check("rw_dec", dec[0], 0);
    check("rw_data", dout[0], 0);
    check("rw_key", key0, 0);
    check("rw_irq", irq[0], 0);
    check("rw_dat", rdat[0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    eng(0, rnd(), 1'b0);
    rdc(0, 8'h04, 32'h0, "rw_status");
    rdc(1, 8'h08, 32'h0, "unmapped_rd");
    wr(1, 8'h08, 32'hffffffff);
    rdc(1, 8'h04, 32'h0, "unmapped_wr");
    e256 = '0;
    for (int k = 0; k < 8; k++) begin
      kw = $urandom;
      e256 = {e256[223:0], kw};
      wr(1, 8'h20 + 8'(4*k), kw);
    end
    check("key256", key1, e256);
    rdc(1, 8'h34, e256[95:64], "key256_rb");
    wr(1, 8'h00, 32'h4);
    rdc(1, 8'h00, IRQB ? 32'h4 : 32'h0, "ctrl_ien");
    wr(1, 8'h00, 32'h5);
    repeat (3) @(posedge clk);
    blk = rnd();
    @(negedge clk);
    rdy[1] = 1'b1; edat[1] = blk;
    check("irq_pre", irq[1], 0);
    @(posedge clk); #1;
    rdy[1] = 1'b0;
    check("irq_rise", irq[1], IRQB);
    rdc(1, 8'h40, blk[127:96], "res256");
    check("irq_hold", irq[1], IRQB);
    rdc(1, 8'h4c, blk[31:0], "res256_pop");
    check("irq_fall", irq[1], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
